// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the IF-stage branch target buffer: widths and
// 2-bit direction counter encodings.
package btb_predictor_pkg;

    localparam int BTB_WORD_SIZE  = 16;
    localparam int BTB_INDEX_BITS = 6;
    localparam int BTB_TAG_BITS   = BTB_WORD_SIZE - BTB_INDEX_BITS;
    localparam int BTB_CTR_BITS   = 2;

    typedef enum logic [BTB_CTR_BITS-1:0] {
        CTR_SNT = 2'd0,
        CTR_WNT = 2'd1,
        CTR_WT  = 2'd2,
        CTR_ST  = 2'd3
    } btb_ctr_e;

    localparam btb_ctr_e CTR_INIT = CTR_WT;

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational next state of a 2-bit saturating direction counter.
module btb_sat_counter
    import btb_predictor_pkg::*;
(
    input  logic [BTB_CTR_BITS-1:0] ctr,
    input  logic                    taken,
    output logic [BTB_CTR_BITS-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped tagged BTB with zero-latency lookup and ID-stage training.
// Define BTB_COUNTER_EN for 2-bit direction counters; otherwise every hit predicts taken.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int WORD_SIZE  = BTB_WORD_SIZE,
    parameter int INDEX_BITS = BTB_INDEX_BITS,
    parameter int TAG_BITS   = WORD_SIZE - INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] predictedPC,
    output logic                 predictHit,
    input  logic                 updEn,
    input  logic [WORD_SIZE-1:0] updPC,
    input  logic [WORD_SIZE-1:0] updTarget,
    input  logic                 updTaken,
    input  logic                 updIsJump
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   jump_q;
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];

    logic [INDEX_BITS-1:0] look_idx;
    logic [TAG_BITS-1:0]   look_tag;
    logic                  look_hit;
    logic                  predict_taken;

    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic                  upd_taken_eff;

    assign look_idx = pc[INDEX_BITS-1:0];
    assign look_tag = pc[WORD_SIZE-1:INDEX_BITS];
    assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

    assign upd_idx       = updPC[INDEX_BITS-1:0];
    assign upd_tag       = updPC[WORD_SIZE-1:INDEX_BITS];
    assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_taken_eff = updTaken || updIsJump;

`ifdef BTB_COUNTER_EN
    logic [BTB_CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [BTB_CTR_BITS-1:0] ctr_next;

    btb_sat_counter u_sat_counter (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken_eff),
        .ctr_next (ctr_next)
    );

    assign predict_taken = look_hit && (jump_q[look_idx] || ctr_q[look_idx][1]);

    // A not-taken miss leaves the counter alone; a taken miss reallocates it.
    always_ff @(posedge clk) begin
        if (updEn && (upd_taken_eff || upd_hit))
            ctr_q[upd_idx] <= upd_hit ? ctr_next : CTR_INIT;
    end
`else
    assign predict_taken = look_hit;
`endif

    assign predictHit  = predict_taken;
    assign predictedPC = predict_taken ? target_q[look_idx] : pc + WORD_SIZE'(1);

    // Only valid bits are reset; stale payload in invalid entries is never used.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (updEn) begin
            if (upd_taken_eff)
                valid_q[upd_idx] <= 1'b1;
`ifndef BTB_COUNTER_EN
            else if (upd_hit)
                valid_q[upd_idx] <= 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (updEn && upd_taken_eff) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= updTarget;
            jump_q[upd_idx]   <= updIsJump;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed vector table plus random
// traffic checked against an array-based reference model.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic [15:0] predictedPC;
    logic        predictHit;
    logic        updEn;
    logic [15:0] updPC;
    logic [15:0] updTarget;
    logic        updTaken;
    logic        updIsJump;

    int errors = 0;
    int checks = 0;

    btb_predictor dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .predictedPC (predictedPC),
        .predictHit  (predictHit),
        .updEn       (updEn),
        .updPC       (updPC),
        .updTarget   (updTarget),
        .updTaken    (updTaken),
        .updIsJump   (updIsJump)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] upc;
        logic [15:0] utgt;
        bit          utk;
        bit          ujmp;
        logic [15:0] lpc;
        logic [15:0] exp_pc;
        bit          exp_hit;
    } vec_t;

    vec_t vecs[$];

    // Reference model: one record per entry, updated by the training rules.
    bit m_valid [64];
    int m_tag   [64];
    int m_tgt   [64];
    bit m_jump  [64];
    int m_ctr   [64];

    function automatic vec_t mk(bit rst, bit en, int upc, int utgt, bit utk, bit ujmp,
                                int lpc, int exp_pc, bit exp_hit);
        vec_t v;
        v.rst = rst; v.en = en; v.upc = 16'(upc); v.utgt = 16'(utgt);
        v.utk = utk; v.ujmp = ujmp; v.lpc = 16'(lpc);
        v.exp_pc = 16'(exp_pc); v.exp_hit = exp_hit;
        return v;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
    endfunction

    function automatic void model_lookup(input int p, output int npc, output bit hit);
        int  idx = p % 64;
        bit  tk;
        tk = m_valid[idx] && (m_tag[idx] == p / 64);
`ifdef BTB_COUNTER_EN
        tk = tk && (m_jump[idx] || m_ctr[idx] >= 2);
`endif
        hit = tk;
        npc = tk ? m_tgt[idx] : (p + 1) % 65536;
    endfunction

    function automatic void model_update(input int p, input int t, input bit tk, input bit j);
        int idx = p % 64;
        bit hit = m_valid[idx] && (m_tag[idx] == p / 64);
        if (tk || j) begin
            m_ctr[idx]   = hit ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3) : 2;
            m_valid[idx] = 1;
            m_tag[idx]   = p / 64;
            m_tgt[idx]   = t;
            m_jump[idx]  = j;
        end else if (hit) begin
`ifdef BTB_COUNTER_EN
            m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
`else
            m_valid[idx] = 0;
`endif
        end
    endfunction

    initial begin
        int npc;
        bit nhit;
        bit do_rst;
        int tg;

        reset_n = 1'b0; pc = 16'h0010;
        updEn = 0; updPC = 0; updTarget = 0; updTaken = 0; updIsJump = 0;
        #1;
        check16("reset_pc", predictedPC, 16'h0011);
        check1("reset_hit", predictHit, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        //          rst en  updPC    target   tk ujmp lookup   expPC    hit
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 1, 'h0010, 'h0040, 1, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0010, 'h0040, 1));
        vecs.push_back(mk(0, 1, 'h0010, 'h0000, 0, 0, 'h0010, 'h0040, 1));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 1, 'h0010, 'h0040, 1, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 1, 'h0010, 'h0040, 1, 0, 'h0010, 'h0040, 1));
        vecs.push_back(mk(0, 1, 'h0010, 'h0000, 0, 0, 'h0010, 'h0040, 1));
`ifdef BTB_COUNTER_EN
        vecs.push_back(mk(0, 1, 'h0010, 'h0000, 0, 0, 'h0010, 'h0040, 1));
`else
        vecs.push_back(mk(0, 1, 'h0010, 'h0000, 0, 0, 'h0010, 'h0011, 0));
`endif
        vecs.push_back(mk(0, 1, 'h0010, 'h0000, 0, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 1, 'h0010, 'h0000, 0, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 1, 'h0050, 'h0070, 1, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0010, 'h0011, 0));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0050, 'h0070, 1));
        vecs.push_back(mk(1, 1, 'h0050, 'h0099, 1, 0, 'h0050, 'h0051, 0));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0050, 'h0051, 0));
        vecs.push_back(mk(0, 1, 'h0020, 'h0100, 0, 1, 'h0020, 'h0021, 0));
        vecs.push_back(mk(0, 1, 'h0020, 'h0000, 0, 0, 'h0020, 'h0100, 1));
`ifdef BTB_COUNTER_EN
        vecs.push_back(mk(0, 1, 'h0020, 'h0000, 0, 0, 'h0020, 'h0100, 1));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0020, 'h0100, 1));
`else
        vecs.push_back(mk(0, 1, 'h0020, 'h0000, 0, 0, 'h0020, 'h0021, 0));
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'h0020, 'h0021, 0));
`endif
        vecs.push_back(mk(0, 0, 'h0000, 'h0000, 0, 0, 'hFFFF, 'h0000, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            pc = vecs[i].lpc;
            updEn = vecs[i].en; updPC = vecs[i].upc; updTarget = vecs[i].utgt;
            updTaken = vecs[i].utk; updIsJump = vecs[i].ujmp;
            if (vecs[i].rst) reset_n = 1'b0;
            #1;
            check16($sformatf("vec%0d_pc", i), predictedPC, vecs[i].exp_pc);
            check1($sformatf("vec%0d_hit", i), predictHit, vecs[i].exp_hit);
            if (vecs[i].rst) begin
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
        end

        // Random traffic on a few indices and tags so hits, aliasing and evictions occur.
        @(negedge clk);
        updEn = 0; reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_clear();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            do_rst = ($urandom_range(0, 59) == 0);
            tg = $urandom_range(0, 3);
            pc = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'(tg * 64 + $urandom_range(0, 3));
            updEn = $urandom_range(0, 1);
            updPC = 16'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
            updTarget = 16'($urandom);
            updTaken = $urandom_range(0, 1);
            updIsJump = ($urandom_range(0, 4) == 0);
            if (do_rst) reset_n = 1'b0;
            #1;
            if (do_rst) begin
                npc = (pc + 1) % 65536;
                nhit = 0;
            end else begin
                model_lookup(pc, npc, nhit);
            end
            check16($sformatf("rand%0d_pc", n), predictedPC, 16'(npc));
            check1($sformatf("rand%0d_hit", n), predictHit, nhit);
            @(posedge clk);
            if (do_rst) begin
                model_clear();
                #1 reset_n = 1'b1;
            end else if (updEn) begin
                model_update(updPC, updTarget, updTaken, updIsJump);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Branch target buffer and direction predictor for the IF stage of the 16-bit pipelined CPU.
- Looks up the current fetch PC combinationally and drives predictedPC, the address fetched next cycle.
- Trained from ID by the hazard-control outputs: btbWrite and isPredict, with the datapath selecting the target per btbSrc.
- Direct-mapped, tagged, with optional 2-bit saturating direction counters.

Parameters:
- WORD_SIZE, 16, address/data width (from opcodes.v).
- INDEX_BITS, 6, log2 of entry count (64 entries).
- TAG_BITS, WORD_SIZE-INDEX_BITS, tag width stored per entry.

Ports:
- clk  input  1  core clock
- reset_n  input  1  asynchronous active-low reset
- pc  input  WORD_SIZE  current fetch PC (IF)
- predictedPC  output  WORD_SIZE  next fetch address
- predictHit  output  1  lookup hit with taken prediction (for debug/perf)
- updEn  input  1  train enable; one update per cycle (isPredict && ID stage advancing)
- updPC  input  WORD_SIZE  PC of the branch/jump in ID
- updTarget  input  WORD_SIZE  resolved target (btbSrc-muxed: brTarget/RF[$rs]/jumpAddr)
- updTaken  input  1  1 = taken (bcond, or any jump)
- updIsJump  input  1  1 = JMP/JAL/JPR/JRL (unconditional)

Behaviour:
- Entry = {valid, isJump, tag[TAG_BITS], target[WORD_SIZE], ctr[2]}.
- Index = pc[INDEX_BITS-1:0]; tag = pc[WORD_SIZE-1:INDEX_BITS].
- Lookup is purely combinational, zero latency:
  - hit = valid && tag match.
  - predictTaken = hit && (isJump || ctr[1]).
  - predictedPC = predictTaken ? target : pc+1, modulo 2^WORD_SIZE; pc=16'hFFFF gives 16'h0000.
  - predictHit = predictTaken.
- Update is synchronous on the posedge of clk when updEn=1. Entry index/tag come from updPC.
  - Taken, entry miss (invalid or tag differs): allocate/replace. valid=1, tag, target=updTarget, isJump=updIsJump, ctr=2'b10.
  - Taken, entry hit: target=updTarget, isJump=updIsJump, ctr=min(ctr+1,3).
  - Not taken, entry hit: ctr=max(ctr-1,0). Entry stays valid; target unchanged.
  - Not taken, entry miss: no change. A not-taken branch never allocates.
  - updIsJump=1 forces taken treatment regardless of updTaken.
- Read/write same index in the same cycle: lookup returns pre-update contents. The new value is visible from the next cycle. No bypass.
- updEn=0: table holds.
- Reset (reset_n=0, asynchronous, any cycle including mid-update):
  - All valid bits clear immediately; pending update is discarded.
  - predictedPC=pc+1, predictHit=0 while in reset.
  - ctr/target/tag need not reset; invalid entries are never used.
- No internal stall handling. Hazard control gates updEn, so one branch is trained once even if ID stalls.

Optional Feature:
- BTB_COUNTER_EN
  - Defined: 2-bit counters implemented as above.
  - Undefined: no ctr storage; every hit predicts taken.
  - Undefined, taken update: allocates/overwrites as above.
  - Undefined, not-taken update on hit: clears valid (evict), so the next lookup predicts pc+1.

Decomposition:
- Shared package/header (alongside opcodes.v):
  - WORD_SIZE.
  - Counter encodings: CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - CTR_INIT=CTR_WT.
  - Entry field widths.
- One natural sub-module, btb_sat_counter: combinational next-state of a 2-bit saturating counter given taken. Instantiated once on the update path; compiled out without BTB_COUNTER_EN.

Test Plan:
- Reset, then pc=16'h0010, no updates -> predictedPC=16'h0011, predictHit=0. Assert reset_n low mid-run -> all previous hits revert to pc+1 within the same cycle.
- updEn=1, updPC=16'h0010, updTarget=16'h0040, updTaken=1 -> same cycle lookup of 16'h0010 gives 16'h0011; next cycle gives 16'h0040, predictHit=1.
- Counters (BTB_COUNTER_EN), after the allocation above:
  - Not-taken once -> ctr=1, predictedPC=16'h0011.
  - Taken twice -> ctr=3.
  - Three not-takens -> ctr=0.
  - Further not-taken -> ctr stays 0.
- Aliasing: train 16'h0010->16'h0040, then train 16'h0050 taken->16'h0070 (same index 6'h10) -> lookup 16'h0010 gives 16'h0011; 16'h0050 gives 16'h0070.
- Jump: updIsJump=1, updTaken=0, updPC=16'h0020, updTarget=16'h0100 -> allocated, predicts 16'h0100. Two not-taken updates (updIsJump=0) with counters -> still predicts while isJump=1.
- Without BTB_COUNTER_EN: allocate 16'h0010->16'h0040, then one not-taken update -> lookup gives 16'h0011.
- pc=16'hFFFF with no entry -> predictedPC=16'h0000.
